// File: rtl/fast9_pkg.sv
// Shared constants, state encoding and arc-counter helper for the FAST-9 corner pipeline.
package fast9_pkg;

  localparam int PIXEL_W     = 8;
  localparam int ADDR_W      = 15;
  localparam int CIRCLE_N    = 16;
  localparam int SLOT_CENTER = 0;
  localparam int SLOT_LAST   = 16;
  localparam int ARC_LEN     = 9;
  // Scan positions needed so every arc start, including ones wrapping 16->1, is seen.
  localparam int SCAN_POS    = CIRCLE_N + ARC_LEN - 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLASSIFY = 2'd1,
    EVAL     = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic [3:0] arc_step(input logic [3:0] run, input logic hit_bit,
                                          input logic [3:0] lim);
    if (!hit_bit) return 4'd0;
    if (run >= lim) return lim;
    return run + 4'd1;
  endfunction

endpackage

// File: rtl/fast9_classify.sv
// Combinational bright/dark classification of the 16 circle pixels against the centre.
module fast9_classify #(
  parameter int PIXEL_W   = fast9_pkg::PIXEL_W,
  parameter int THRESHOLD = 20
) (
  input  logic [PIXEL_W-1:0]    centre,
  input  logic [16*PIXEL_W-1:0] circle,
  output logic [15:0]           bright,
  output logic [15:0]           dark
);
  import fast9_pkg::*;

  // Two guard bits keep c+t and p+t free of wrap-around.
  localparam int EXT_W = PIXEL_W + 2;
  localparam logic [EXT_W-1:0] T_EXT = EXT_W'(THRESHOLD);

  logic [EXT_W-1:0] c_ext;
  assign c_ext = {2'b00, centre};

  genvar gi;
  for (gi = 0; gi < CIRCLE_N; gi++) begin : g_cmp
    logic [EXT_W-1:0] p_ext;
    assign p_ext      = {2'b00, circle[gi*PIXEL_W +: PIXEL_W]};
    assign bright[gi] = p_ext > (c_ext + T_EXT);
    assign dark[gi]   = (p_ext + T_EXT) < c_ext;
  end

endmodule

// File: rtl/fast9_corner_eval.sv
// FAST-9 corner evaluator: captures 17 slots, classifies on readen, scans 2 positions/cycle for a 9-arc.
module fast9_corner_eval #(
  parameter int PIXEL_W   = fast9_pkg::PIXEL_W,
  parameter int ADDR_W    = fast9_pkg::ADDR_W,
  parameter int THRESHOLD = 20,
  parameter int ARC_LEN   = fast9_pkg::ARC_LEN
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [PIXEL_W-1:0] pixelIn,
  input  logic              pixelValid,
  input  logic [4:0]        regAddr,
  input  logic              readen,
  input  logic [ADDR_W-1:0] refAddr,
  output logic              busy,
  output logic              cornerValid,
  output logic              isCorner,
  output logic              cornerDark,
  output logic [ADDR_W-1:0] cornerAddr,
  output logic              overrun
);
  import fast9_pkg::*;

  localparam logic [3:0] ARC_LIM  = 4'(ARC_LEN);
  localparam logic [3:0] EVAL_END = 4'(SCAN_POS / 2 - 1);

  state_t state_q, state_d;

  logic [PIXEL_W-1:0] buf_q [0:SLOT_LAST];
  logic [PIXEL_W-1:0] buf_d [0:SLOT_LAST];
  logic [15:0]        bright_mask_q, bright_mask_d, dark_mask_q, dark_mask_d;
  logic [3:0]         run_b_q, run_b_d, run_k_q, run_k_d, eval_cnt_q, eval_cnt_d;
  logic               hit_b_q, hit_b_d, hit_k_q, hit_k_d;
  logic [ADDR_W-1:0]  addr_q, addr_d, corner_addr_q, corner_addr_d;
  logic               is_corner_q, is_corner_d, corner_dark_q, corner_dark_d;
  logic               overrun_q, overrun_d;

  logic [16*PIXEL_W-1:0] circle_w;
  logic [15:0]           bright_w, dark_w;
  logic [3:0]            idx0, idx1, run_b_mid, run_k_mid;

  always_comb begin
    circle_w = '0;
    for (int i = 0; i < CIRCLE_N; i++) circle_w[i*PIXEL_W +: PIXEL_W] = buf_q[i+1];
  end

  fast9_classify #(.PIXEL_W(PIXEL_W), .THRESHOLD(THRESHOLD)) u_classify (
    .centre (buf_q[SLOT_CENTER]),
    .circle (circle_w),
    .bright (bright_w),
    .dark   (dark_w)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      for (int i = 0; i <= SLOT_LAST; i++) buf_q[i] <= '0;
      bright_mask_q <= '0;
      dark_mask_q   <= '0;
      run_b_q       <= '0;
      run_k_q       <= '0;
      eval_cnt_q    <= '0;
      hit_b_q       <= 1'b0;
      hit_k_q       <= 1'b0;
      addr_q        <= '0;
      corner_addr_q <= '0;
      is_corner_q   <= 1'b0;
      corner_dark_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      for (int i = 0; i <= SLOT_LAST; i++) buf_q[i] <= buf_d[i];
      bright_mask_q <= bright_mask_d;
      dark_mask_q   <= dark_mask_d;
      run_b_q       <= run_b_d;
      run_k_q       <= run_k_d;
      eval_cnt_q    <= eval_cnt_d;
      hit_b_q       <= hit_b_d;
      hit_k_q       <= hit_k_d;
      addr_q        <= addr_d;
      corner_addr_q <= corner_addr_d;
      is_corner_q   <= is_corner_d;
      corner_dark_q <= corner_dark_d;
      overrun_q     <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (readen) state_d = CLASSIFY;
      CLASSIFY: state_d = EVAL;
      EVAL:     if (eval_cnt_q == EVAL_END) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    cornerValid = (state_q == DONE);
  end

  assign isCorner   = is_corner_q;
  assign cornerDark = corner_dark_q;
  assign cornerAddr = corner_addr_q;
  assign overrun    = overrun_q;

  // Scan index k = 2*eval_cnt (+1); mask bit (k mod 16) is circle position (k mod 16)+1.
  assign idx0      = {eval_cnt_q[2:0], 1'b0};
  assign idx1      = {eval_cnt_q[2:0], 1'b1};
  assign run_b_mid = arc_step(run_b_q, bright_mask_q[idx0], ARC_LIM);
  assign run_k_mid = arc_step(run_k_q, dark_mask_q[idx0], ARC_LIM);

  always_comb begin
    for (int i = 0; i <= SLOT_LAST; i++) buf_d[i] = buf_q[i];
    bright_mask_d = bright_mask_q;
    dark_mask_d   = dark_mask_q;
    run_b_d       = run_b_q;
    run_k_d       = run_k_q;
    eval_cnt_d    = eval_cnt_q;
    hit_b_d       = hit_b_q;
    hit_k_d       = hit_k_q;
    addr_d        = addr_q;
    corner_addr_d = corner_addr_q;
    is_corner_d   = is_corner_q;
    corner_dark_d = corner_dark_q;
    overrun_d     = overrun_q;

    for (int i = 0; i <= SLOT_LAST; i++)
      if (pixelValid && regAddr == 5'(i)) buf_d[i] = pixelIn;

    if (readen) begin
      if (state_q == IDLE) addr_d = refAddr;
      else                 overrun_d = 1'b1;
    end

    case (state_q)
      CLASSIFY: begin
        bright_mask_d = bright_w;
        dark_mask_d   = dark_w;
        run_b_d       = '0;
        run_k_d       = '0;
        eval_cnt_d    = '0;
        hit_b_d       = 1'b0;
        hit_k_d       = 1'b0;
      end
      EVAL: begin
        run_b_d    = arc_step(run_b_mid, bright_mask_q[idx1], ARC_LIM);
        run_k_d    = arc_step(run_k_mid, dark_mask_q[idx1], ARC_LIM);
        hit_b_d    = hit_b_q | (run_b_mid == ARC_LIM) | (run_b_d == ARC_LIM);
        hit_k_d    = hit_k_q | (run_k_mid == ARC_LIM) | (run_k_d == ARC_LIM);
        eval_cnt_d = eval_cnt_q + 4'd1;
        if (eval_cnt_q == EVAL_END) begin
          is_corner_d   = hit_b_d | hit_k_d;
          corner_dark_d = hit_k_d & ~hit_b_d;
          corner_addr_d = addr_q;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/fast9_corner_eval.md
Name: fast9_corner_eval

Overview:
- Downstream consumer of the FAST-9 address/slot sequencer.
- Captures the 17 pixels the sequencer fetches per candidate: slot 0 is the centre, slots 1..16 are the Bresenham circle in circular order.
- On the load-complete strobe, snapshots and classifies the 16 circle pixels against the centre, then scans serially for a contiguous arc of ARC_LEN brighter or darker pixels. Arcs may wrap across slot 16→1.
- Emits a one-cycle corner verdict tagged with the candidate pixel address.

Parameters:
- PIXEL_W, 8, pixel intensity width.
- ADDR_W, 15, pixel address width (covers the 180x120 frame).
- THRESHOLD, 20, intensity margin t.
- ARC_LEN, 9, required contiguous arc length.

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- pixelIn  in  PIXEL_W  pixel data for the slot on regAddr.
- pixelValid  in  1  pixelIn/regAddr qualifier.
- regAddr  in  5  capture slot 0..16; values 17..31 ignored.
- readen  in  1  load-complete strobe, asserted in the same cycle as the slot-16 write.
- refAddr  in  ADDR_W  candidate address; sampled when readen=1.
- busy  out  1  high in CLASSIFY/EVAL/DONE.
- cornerValid  out  1  one-cycle result strobe.
- isCorner  out  1  verdict, valid with cornerValid.
- cornerDark  out  1  1=dark arc, 0=bright arc; 0 when not a corner.
- cornerAddr  out  ADDR_W  latched refAddr, held until next result.
- overrun  out  1  sticky: readen arrived while busy; cleared only by reset.

Behaviour:
- Reset (synchronous): all outputs 0, capture buffer 0, masks 0, counters 0, state IDLE. A reset mid-EVAL discards the candidate; no cornerValid is produced.
- Capture: when pixelValid=1 and regAddr≤16, write buf[regAddr] at the clock edge. Capture runs in every state, so the next candidate loads while the current one evaluates.
- readen in IDLE:
  - latch refAddr into an address holding register;
  - next state CLASSIFY;
  - the slot-16 write made in that same cycle is visible to CLASSIFY.
- readen while busy: ignored, overrun←1, current evaluation unaffected.
- CLASSIFY (1 cycle), for i=1..16, compare at PIXEL_W+2 bits, unsigned extended:
  - bright[i] = buf[i] > buf[0]+THRESHOLD;
  - dark[i] = buf[i] + THRESHOLD < buf[0];
  - equality at the margin is neither bright nor dark;
  - no wrap or saturation artefacts;
  - the 16-bit masks are latched; buf may then be overwritten freely.
- EVAL (12 cycles):
  - processes 2 circle positions per cycle, scan index k=0..23, position (k mod 16)+1;
  - runBright/runDark are 4-bit counters: increment on mask bit, clear on 0, saturate at ARC_LEN;
  - the hit flag is set if either counter reaches ARC_LEN;
  - the bright hit takes priority for cornerDark; both at once cannot occur (exclusive masks);
  - 24 positions cover every wrap-around start.
- DONE (1 cycle): cornerValid=1, isCorner=hit, cornerDark=dark hit && !bright hit, cornerAddr=latched address → IDLE.
- Latency: readen at cycle N → cornerValid at N+14. This is under the 17-cycle sequencer period, so there are no overruns at nominal rate.
- Masks of all-1 bright (16 pixels) → corner. 8 contiguous with a 1-gap either side → not corner.

Decomposition:
- Shared package fast9_pkg:
  - PIXEL_W, ADDR_W, CIRCLE_N=16, SLOT_CENTER=0, SLOT_LAST=16, ARC_LEN;
  - state enum {IDLE, CLASSIFY, EVAL, DONE}.
- One sub-module fast9_classify, combinational: centre + 16 pixels + threshold → bright/dark masks. Reusable by a future score stage.

Test Plan:
- Centre 100, all circle 100, readen with refAddr=543 → cornerValid at N+14, isCorner=0, cornerAddr=543.
- Centre 100, slots 1..9=121, rest 100 → isCorner=1, cornerDark=0.
- Centre 100, slots 13..16 and 1..5=79, rest 100 (wrapped arc of 9) → isCorner=1, cornerDark=1.
- Centre 100, slots 1..8=121, slot 9=120 (exactly c+t), rest 100 → isCorner=0.
- Centre 10, all circle 0 (dark impossible, t=20) → isCorner=0. Centre 250, all circle 255 → isCorner=0, no overflow.
- Back-to-back candidates at a 17-cycle period produce two results with overrun=0. readen 5 cycles after the prior one gives overrun=1 and the first result unaffected. reset asserted at N+6 gives no cornerValid and all outputs 0.
